// File: rtl/foxtrot_pkg.sv
// foxtrot_pkg: shared memory-word geometry and fetch-stage definitions
package foxtrot_pkg;
    localparam int MEM_WORD_BITS = 64;
    localparam int MEM_ADDR_BITS = 64;
    localparam int WORD_OFF_BITS = 3;

    typedef logic [MEM_WORD_BITS-1:0] mem_word_t;
    typedef logic [MEM_ADDR_BITS-1:0] mem_addr_t;

    typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_WAIT} fetch_state_e;

    typedef struct packed {
        logic      valid;
        mem_addr_t pc;
    } fetch_req_t;

    function automatic mem_addr_t word_of(input mem_addr_t a);
        return a >> WORD_OFF_BITS;
    endfunction
endpackage

// File: rtl/imem_responder_resp_pipe.sv
// resp_pipe: fixed-latency valid/data delay line with flush; data is zero whenever valid is low
module resp_pipe #(
    parameter int LATENCY = 1,
    parameter int W       = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [LATENCY-1:0]        vld;
    logic [LATENCY-1:0][W-1:0] dat;

    // shift stages every cycle; reset and flush empty the whole line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            dat <= '0;
        end else if (flush) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_data  = dat[LATENCY-1];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: loadable instruction memory answering fetch reads after a fixed latency
module imem_responder
    import foxtrot_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_ren,
    input  logic [MEM_ADDR_BITS-1:0] mem_raddr,
    output logic                     mem_rvalid,
    output logic [MEM_WORD_BITS-1:0] mem_rdata,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [MEM_ADDR_BITS-1:0] load_addr,
    input  logic [MEM_WORD_BITS-1:0] load_data,
    output logic                     oob_err,
    output logic [2:0]               inflight
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_word_t mem [DEPTH_WORDS];
    mem_addr_t rd_w, ld_w;
    mem_word_t rd_data;
    logic      rd_in, ld_in, acc;

    assign rd_w  = word_of(mem_raddr);
    assign ld_w  = word_of(load_addr);
    assign rd_in = (rd_w >> IDX_W) == '0;
    assign ld_in = (ld_w >> IDX_W) == '0;
    assign acc   = mem_ren & ~flush;

    // a same-cycle load to the read word bypasses the array; out-of-range reads return 0
    always_comb begin
        rd_data = (load_en && ld_in && ld_w == rd_w) ? load_data : rd_in ? mem[rd_w[IDX_W-1:0]] : '0;
    end

    // program load; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (load_en && ld_in) mem[ld_w[IDX_W-1:0]] <= load_data;
    end

    // sticky range error and in-flight request count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oob_err  <= 1'b0;
            inflight <= '0;
        end else begin
            oob_err  <= oob_err | (acc & ~rd_in) | (load_en & ~ld_in);
            inflight <= flush ? 3'd0 : inflight + 3'(acc) - 3'(mem_rvalid);
        end
    end

    resp_pipe #(.LATENCY(LATENCY), .W(MEM_WORD_BITS)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (acc),
        .in_data  (rd_data),
        .out_valid(mem_rvalid),
        .out_data (mem_rdata)
    );
endmodule
